// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-class character LCD controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_LOAD,
        BUS_SETUP,
        BUS_PULSE,
        BUS_HOLD,
        EXEC_WAIT,
        IDLE
    } state_t;

    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_DISP_ON = 8'h0C;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_FS_BASE = 8'h20;

    // Wake-up nibble used by the 4-bit init handshake.
    localparam logic [7:0] CMD_WAKE    = 8'h30;
    localparam int unsigned WAKE_US    = 4100;

    function automatic logic [7:0] fs_byte(
        input logic four,
        input logic two_line,
        input logic font
    );
        return CMD_FS_BASE | {3'b000, ~four, two_line, font, 2'b00};
    endfunction

endpackage

// File: rtl/lcd_ctrl_tick.sv
// Microsecond tick enable: one-cycle pulse every CLK_HZ/1e6 clocks.
module us_tick_gen #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

    localparam int unsigned DIV = CLK_HZ / 1_000_000;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TOP = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == TOP) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/lcd_ctrl.sv
// Character LCD controller: init sequence, then handshaked
// command/data writes, 8-bit or 4-bit bus, tick-timed EN cycles.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BUS_4BIT   = 0,
    parameter int unsigned TWO_LINE   = 1,
    parameter int unsigned FONT_5X11  = 0,
    parameter int unsigned POWERON_US = 20000,
    parameter int unsigned CMD_US     = 40,
    parameter int unsigned CLEAR_US   = 1600
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       init_done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    localparam logic NIB = (BUS_4BIT != 0);
    localparam logic [7:0] FS =
        fs_byte(NIB, TWO_LINE != 0, FONT_5X11 != 0);
    localparam logic [2:0] LAST = NIB ? 3'd7 : 3'd3;

    localparam logic [20:0] W_PWR  = 21'(POWERON_US);
    localparam logic [20:0] W_CMD  = 21'(CMD_US);
    localparam logic [20:0] W_CLR  = 21'(CLEAR_US);
    localparam logic [20:0] W_WAKE = 21'(WAKE_US);

    state_t      state;
    logic        tick;
    logic [20:0] cnt;
    logic [20:0] wait_q;
    logic [2:0]  ptr;
    logic [3:0]  lo_q;
    logic        nib_only;
    logic        low_phase;

    logic [7:0]  rom_byte;
    logic        rom_nib;
    logic        rom_long;

    us_tick_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_tick (
        .CLK (CLK),
        .RST (RST),
        .tick(tick)
    );

    assign lcd_rw = 1'b0;

    function automatic logic [20:0] exec_ticks(
        input logic       rs,
        input logic [7:0] b
    );
        if (!rs && (b == CMD_CLEAR || b == CMD_HOME || b == 8'h03))
            return W_CLR;
        return W_CMD;
    endfunction

    function automatic logic [7:0] hi_bus(input logic [7:0] b);
        return NIB ? {b[7:4], 4'h0} : b;
    endfunction

    // 4-bit mode prepends the single-nibble wake/width handshake.
    always_comb begin
        rom_byte = FS;
        rom_nib  = 1'b0;
        rom_long = 1'b0;
        if (NIB) begin
            unique case (ptr)
                3'd0: begin
                    rom_byte = CMD_WAKE;
                    rom_nib  = 1'b1;
                    rom_long = 1'b1;
                end
                3'd1, 3'd2: begin
                    rom_byte = CMD_WAKE;
                    rom_nib  = 1'b1;
                end
                3'd3: begin
                    rom_byte = CMD_FS_BASE;
                    rom_nib  = 1'b1;
                end
                3'd4: rom_byte = FS;
                3'd5: rom_byte = CMD_DISP_ON;
                3'd6: rom_byte = CMD_CLEAR;
                default: rom_byte = CMD_ENTRY;
            endcase
        end else begin
            unique case (ptr[1:0])
                2'd0: rom_byte = FS;
                2'd1: rom_byte = CMD_DISP_ON;
                2'd2: rom_byte = CMD_CLEAR;
                default: rom_byte = CMD_ENTRY;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= PWR_WAIT;
            cnt       <= W_PWR - 21'd1;
            wait_q    <= W_CMD;
            ptr       <= 3'd0;
            lo_q      <= 4'h0;
            nib_only  <= 1'b0;
            low_phase <= 1'b0;
            lcd_en    <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
            in_ready  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            unique case (state)
                PWR_WAIT: begin
                    if (tick) begin
                        if (cnt == 21'd0) state <= INIT_LOAD;
                        else cnt <= cnt - 21'd1;
                    end
                end
                INIT_LOAD: begin
                    lcd_rs    <= 1'b0;
                    lcd_data  <= hi_bus(rom_byte);
                    lo_q      <= rom_byte[3:0];
                    nib_only  <= rom_nib;
                    low_phase <= 1'b0;
                    wait_q    <= rom_long ? W_WAKE
                                          : exec_ticks(1'b0, rom_byte);
                    state     <= BUS_SETUP;
                end
                BUS_SETUP: begin
                    if (tick) begin
                        lcd_en <= 1'b1;
                        state  <= BUS_PULSE;
                    end
                end
                BUS_PULSE: begin
                    if (tick) begin
                        lcd_en <= 1'b0;
                        state  <= BUS_HOLD;
                    end
                end
                BUS_HOLD: begin
                    if (tick) begin
                        if (NIB && !nib_only && !low_phase) begin
                            low_phase <= 1'b1;
                            lcd_data  <= {lo_q, 4'h0};
                            state     <= BUS_SETUP;
                        end else begin
                            cnt   <= wait_q - 21'd1;
                            state <= EXEC_WAIT;
                        end
                    end
                end
                EXEC_WAIT: begin
                    if (tick) begin
                        if (cnt != 21'd0) begin
                            cnt <= cnt - 21'd1;
                        end else if (init_done || ptr == LAST) begin
                            init_done <= 1'b1;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            ptr   <= ptr + 3'd1;
                            state <= INIT_LOAD;
                        end
                    end
                end
                IDLE: begin
                    // Byte is captured here; later in_data changes are ignored.
                    if (in_valid && in_ready) begin
                        in_ready  <= 1'b0;
                        lcd_rs    <= in_rs;
                        lcd_data  <= hi_bus(in_data);
                        lo_q      <= in_data[3:0];
                        nib_only  <= 1'b0;
                        low_phase <= 1'b0;
                        wait_q    <= exec_ticks(in_rs, in_data);
                        state     <= BUS_SETUP;
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: 8-bit and 4-bit instances, pulse scoreboards,
// vector table of writes with wait windows, reset-in-pulse sequence.
module tb_lcd_ctrl;

    typedef struct {
        logic       rs;
        logic [7:0] data;
    } bus_t;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         lo;
        int         hi;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, v8, rs8i, rdy8, done8, lrs8, rw8, en8;
    logic [7:0] d8i, data8;
    logic       rst4, v4, rs4i, rdy4, done4, lrs4, rw4, en4;
    logic [7:0] d4i, data4;

    int checks = 0;
    int errors = 0;
    bit seq4_done = 1'b0;

    bus_t       q8[$];
    logic [3:0] q4[$];

    lcd_ctrl #(
        .CLK_HZ(2_000_000), .BUS_4BIT(0), .TWO_LINE(1),
        .FONT_5X11(0), .POWERON_US(20), .CMD_US(4), .CLEAR_US(16)
    ) dut8 (
        .CLK(clk), .RST(rst8), .in_valid(v8), .in_ready(rdy8),
        .in_rs(rs8i), .in_data(d8i), .init_done(done8),
        .lcd_data(data8), .lcd_rs(lrs8), .lcd_rw(rw8), .lcd_en(en8)
    );

    lcd_ctrl #(
        .CLK_HZ(2_000_000), .BUS_4BIT(1), .TWO_LINE(1),
        .FONT_5X11(0), .POWERON_US(20), .CMD_US(4), .CLEAR_US(16)
    ) dut4 (
        .CLK(clk), .RST(rst4), .in_valid(v4), .in_ready(rdy4),
        .in_rs(rs4i), .in_data(d4i), .init_done(done4),
        .lcd_data(data4), .lcd_rs(lrs4), .lcd_rw(rw4), .lcd_en(en4)
    );

    task automatic chk(input bit ok, input string nm,
                       input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic push_init8();
        q8.push_back('{1'b0, 8'h38});
        q8.push_back('{1'b0, 8'h0C});
        q8.push_back('{1'b0, 8'h01});
        q8.push_back('{1'b0, 8'h06});
    endtask

    task automatic do_write(input bit four, input logic rs,
                            input logic [7:0] d, output int n);
        int b = 0;
        @(negedge clk);
        while (!(four ? rdy4 : rdy8) && b < 2000) begin
            @(negedge clk);
            b++;
        end
        chk(b < 2000, "ready_wait", b, 0);
        if (four) begin
            q4.push_back(d[7:4]);
            q4.push_back(d[3:0]);
            v4 = 1'b1; rs4i = rs; d4i = d;
        end else begin
            q8.push_back('{rs, d});
            v8 = 1'b1; rs8i = rs; d8i = d;
        end
        @(posedge clk);
        #1;
        if (four) begin v4 = 1'b0; d4i = 8'hFF; end
        else begin v8 = 1'b0; d8i = 8'hFF; end
        n = 0;
        while (!(four ? rdy4 : rdy8) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // 8-bit pulse monitor: content, setup/hold stability, clear gap.
    initial begin : mon8
        logic pen = 1'b0;
        logic [7:0] pd = 8'h00, cap = 8'h00;
        logic crs = 1'b0, last_clr = 1'b0;
        int gap = 0;
        bus_t e;
        forever begin
            @(negedge clk);
            if (rst8) begin
                pen = 1'b0; gap = 0; last_clr = 1'b0;
            end else begin
                if (en8 && !pen) begin
                    if (q8.size() == 0) begin
                        chk(1'b0, "unexpected_pulse8", data8, 0);
                    end else begin
                        e = q8.pop_front();
                        chk(lrs8 == e.rs, "rs8", lrs8, e.rs);
                        chk(data8 == e.data, "data8", data8, e.data);
                        chk(data8 == pd, "setup8", data8, pd);
                        chk(rw8 == 1'b0, "rw8", rw8, 0);
                        if (last_clr) chk(gap >= 32, "clr_gap8", gap, 32);
                        last_clr = !e.rs && e.data == 8'h01;
                    end
                    cap = data8; crs = lrs8;
                end
                if (!en8 && pen) begin
                    chk(data8 == cap && lrs8 == crs, "hold8", data8, cap);
                    gap = 0;
                end else if (!en8) begin
                    gap++;
                end
                pen = en8; pd = data8;
            end
        end
    end

    initial begin : mon4
        logic pen = 1'b0;
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (rst4) begin
                pen = 1'b0;
            end else begin
                if (en4 && !pen) begin
                    if (q4.size() == 0) begin
                        chk(1'b0, "unexpected_pulse4", data4, 0);
                    end else begin
                        e = q4.pop_front();
                        chk(data4[7:4] == e, "nib4", data4[7:4], e);
                        chk(data4[3:0] == 4'h0, "low4", data4[3:0], 0);
                    end
                end
                pen = en4;
            end
        end
    end

    initial begin : seq4
        int n;
        logic [3:0] nibs [12];
        nibs = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};
        rst4 = 1'b1; v4 = 1'b0; rs4i = 1'b0; d4i = 8'h00;
        for (int i = 0; i < 12; i++) q4.push_back(nibs[i]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({rdy4, done4, data4, lrs4, rw4, en4} == 13'd0,
            "reset4", {rdy4, done4, data4, lrs4, rw4, en4}, 0);
        rst4 = 1'b0;
        n = 0;
        while (!done4 && n < 12000) begin
            @(negedge clk);
            n++;
        end
        chk(done4 && rdy4, "init_done4", {done4, rdy4}, 3);
        chk(q4.size() == 0, "init_seq4", q4.size(), 0);
        do_write(1'b1, 1'b1, 8'h41, n);
        chk(n >= 19 && n <= 20, "busy4_data", n, 20);
        do_write(1'b1, 1'b0, 8'h01, n);
        chk(n >= 43 && n <= 44, "busy4_clear", n, 44);
        repeat (20) @(negedge clk);
        chk(q4.size() == 0, "drain4", q4.size(), 0);
        seq4_done = 1'b1;
    end

    initial begin : main
        int n;
        vec_t vec [6];
        vec[0] = '{1'b1, 8'h41, 13, 14};
        vec[1] = '{1'b0, 8'h01, 37, 38};
        vec[2] = '{1'b0, 8'h80, 13, 14};
        vec[3] = '{1'b0, 8'h02, 37, 38};
        vec[4] = '{1'b1, 8'h03, 13, 14};
        vec[5] = '{1'b0, 8'h03, 37, 38};

        rst8 = 1'b1; v8 = 1'b0; rs8i = 1'b0; d8i = 8'h00;
        push_init8();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({rdy8, done8, data8, lrs8, rw8, en8} == 13'd0,
            "reset8", {rdy8, done8, data8, lrs8, rw8, en8}, 0);
        rst8 = 1'b0;

        for (int pass = 0; pass < 2; pass++) begin
            n = 0;
            while (!en8 && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk(n >= 40 && n < 300, "pwr_wait8", n, 40);
            n = 0;
            while (!done8 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk(done8 && rdy8, "init_done8", {done8, rdy8}, 3);
            chk(q8.size() == 0, "init_seq8", q8.size(), 0);
            if (pass == 1) break;

            for (int i = 0; i < 6; i++) begin
                do_write(1'b0, vec[i].rs, vec[i].data, n);
                if (!(n >= vec[i].lo && n <= vec[i].hi))
                    $display("vector %0d out of window", i);
                chk(n >= vec[i].lo && n <= vec[i].hi, "busy8", n, vec[i].hi);
            end

            // Back-to-back with in_valid held and data changed while busy.
            @(negedge clk);
            v8 = 1'b1; rs8i = 1'b1; d8i = 8'h48;
            q8.push_back('{1'b1, 8'h48});
            @(posedge clk);
            #1;
            chk(rdy8 == 1'b0, "ready_fall", rdy8, 0);
            d8i = 8'h49;
            q8.push_back('{1'b1, 8'h49});
            n = 0;
            while (!rdy8 && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk(n < 200, "b2b_rearm", n, 0);
            @(posedge clk);
            #1;
            v8 = 1'b0;
            n = 0;
            while (!rdy8 && n < 200) begin
                @(negedge clk);
                n++;
            end
            repeat (20) @(negedge clk);
            chk(q8.size() == 0, "b2b_drain", q8.size(), 0);

            // Reset while EN is high.
            @(negedge clk);
            v8 = 1'b1; rs8i = 1'b1; d8i = 8'h55;
            q8.push_back('{1'b1, 8'h55});
            @(posedge clk);
            #1;
            v8 = 1'b0;
            n = 0;
            while (!en8 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk(en8, "reach_pulse", en8, 1);
            #1;
            rst8 = 1'b1;
            @(posedge clk);
            #1;
            chk({rdy8, done8, data8, lrs8, rw8, en8} == 13'd0,
                "rst_in_pulse", {rdy8, done8, data8, lrs8, rw8, en8}, 0);
            repeat (2) @(posedge clk);
            q8.delete();
            push_init8();
            @(negedge clk);
            rst8 = 1'b0;
        end

        n = 0;
        while (!seq4_done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk(seq4_done, "seq4_timeout", seq4_done, 1);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
